// File: rtl/tm_acc_pkg.sv
// Shared definitions for the TM clause-engine accelerator blocks:
// scan-generator FSM encoding and global limits.
package tm_acc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_COUNT = 2'd2,
    ST_SCAN  = 2'd3
  } state_e;

  localparam int MAX_STRIDE    = 7;
  localparam int DEFAULT_LANES = 8;

endpackage

// File: rtl/therm_enc.sv
// Unsigned value to N-bit thermometer code: bit i is set when i < value.
// Purely combinational; the parent registers the result.
module therm_enc #(
  parameter int N  = 32,
  parameter int VW = $clog2(N) + 1
) (
  input  logic [VW-1:0] i_value,
  output logic [N-1:0]  o_therm
);

  always_comb begin
    // NOTE: give every always_comb output a default first so no path can infer a latch.
    o_therm = '0;
    for (int i = 0; i < N; i++) begin
      o_therm[i] = (VW'(i) < i_value);
    end
  end

endmodule

// File: rtl/patch_scan_gen.sv
// Patch position scan generator: validates a patch/stride config, counts positions by
// repeated subtraction, then streams LANES vertically adjacent positions per beat.
module patch_scan_gen
  import tm_acc_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int HEIGHT    = 32,
  parameter int MAX_PATCH = 7,
  parameter int LANES     = DEFAULT_LANES,
  parameter int XW        = $clog2(WIDTH) + 1,
  parameter int YW        = $clog2(HEIGHT) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [2:0]        patch_size,
  input  logic [2:0]        stride,
  input  logic [XW-1:0]     image_width,
  input  logic [YW-1:0]     image_height,
  output logic              busy,
  output logic              cfg_err,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XW-1:0]     out_x,
  output logic [YW-1:0]     out_y,
  output logic [LANES-1:0]  lane_mask,
  output logic [WIDTH-1:0]  x_therm,
  output logic [HEIGHT-1:0] y_therm,
  output logic              last,
  output logic              done
);

  localparam int CW = 16;
  typedef logic [CW-1:0] cnt_t;

  state_e      r_state;
  logic [2:0]  r_p, r_s;
  logic [XW-1:0] r_w;
  logic [YW-1:0] r_h;
  cnt_t        r_rx, r_ry, r_nx, r_ny, r_xi, r_yb;

  logic              r_cfg_err, r_out_valid, r_last, r_done;
  logic [XW-1:0]     r_out_x;
  logic [YW-1:0]     r_out_y;
  logic [LANES-1:0]  r_lane_mask;
  logic [WIDTH-1:0]  r_x_therm;
  logic [HEIGHT-1:0] r_y_therm;

  cnt_t              w_s, w_beats, w_nxt_xi, w_nxt_yb, w_nxt_base;
  logic              w_rx_ge, w_ry_ge, w_count_done, w_reject;
  logic              w_accept, w_col_end, w_scan_end, w_ld, w_nxt_last;
  logic [XW-1:0]     w_nxt_x;
  logic [YW-1:0]     w_nxt_y;
  logic [LANES-1:0]  w_nxt_mask;
  logic [WIDTH-1:0]  w_x_therm;
  logic [HEIGHT-1:0] w_y_therm;

  always_comb begin
    w_s          = cnt_t'(r_s);
    w_rx_ge      = (r_rx >= w_s);
    w_ry_ge      = (r_ry >= w_s);
    w_count_done = !w_rx_ge && !w_ry_ge;
    w_beats      = (r_ny + cnt_t'(LANES - 1)) / cnt_t'(LANES);
    w_reject     = (r_p == 3'd0) || (r_s == 3'd0) ||
                   (cnt_t'(r_p) > cnt_t'(MAX_PATCH)) || (cnt_t'(r_s) > cnt_t'(MAX_STRIDE)) ||
                   (cnt_t'(r_p) > cnt_t'(r_w)) || (cnt_t'(r_p) > cnt_t'(r_h)) ||
                   (cnt_t'(r_w) > cnt_t'(WIDTH)) || (cnt_t'(r_h) > cnt_t'(HEIGHT));

    w_accept   = r_out_valid && out_ready;
    w_col_end  = (r_yb == w_beats - cnt_t'(1));
    w_scan_end = w_col_end && (r_xi == r_nx - cnt_t'(1));

    // Next beat position: the first beat on leaving COUNT, else the successor of an accepted beat.
    w_ld     = 1'b0;
    w_nxt_xi = r_xi;
    w_nxt_yb = r_yb;
    if (r_state == ST_COUNT && w_count_done) begin
      w_ld     = 1'b1;
      w_nxt_xi = '0;
      w_nxt_yb = '0;
    end else if (r_state == ST_SCAN && w_accept && !w_scan_end) begin
      w_ld = 1'b1;
      if (w_col_end) begin
        w_nxt_xi = r_xi + cnt_t'(1);
        w_nxt_yb = '0;
      end else begin
        w_nxt_yb = r_yb + cnt_t'(1);
      end
    end

    w_nxt_base = w_nxt_yb * cnt_t'(LANES);
    w_nxt_x    = XW'(w_nxt_xi * w_s);
    w_nxt_y    = YW'(w_nxt_base * w_s);
    w_nxt_mask = '0;
    for (int j = 0; j < LANES; j++) begin
      w_nxt_mask[j] = ((w_nxt_base + cnt_t'(j)) < r_ny);
    end
    w_nxt_last = (w_nxt_xi == r_nx - cnt_t'(1)) && (w_nxt_yb == w_beats - cnt_t'(1));
  end

  // Thermometers are encoded from the next coordinates so they register alongside out_x/out_y.
  therm_enc #(.N(WIDTH), .VW(XW)) u_x_therm (
    .i_value (w_nxt_x),
    .o_therm (w_x_therm)
  );

  therm_enc #(.N(HEIGHT), .VW(YW)) u_y_therm (
    .i_value (w_nxt_y),
    .o_therm (w_y_therm)
  );

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      r_state     <= ST_IDLE;
      r_p         <= '0;
      r_s         <= '0;
      r_w         <= '0;
      r_h         <= '0;
      r_rx        <= '0;
      r_ry        <= '0;
      r_nx        <= '0;
      r_ny        <= '0;
      r_xi        <= '0;
      r_yb        <= '0;
      r_cfg_err   <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_x     <= '0;
      r_out_y     <= '0;
      r_lane_mask <= '0;
      r_x_therm   <= '0;
      r_y_therm   <= '0;
      r_last      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_cfg_err <= 1'b0;
      r_done    <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_p     <= patch_size;
            r_s     <= stride;
            r_w     <= image_width;
            r_h     <= image_height;
            r_state <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (abort) begin
            r_state <= ST_IDLE;
          end else if (w_reject) begin
            r_cfg_err <= 1'b1;
            r_state   <= ST_IDLE;
          end else begin
            r_rx    <= cnt_t'(r_w) - cnt_t'(r_p);
            r_ry    <= cnt_t'(r_h) - cnt_t'(r_p);
            r_nx    <= cnt_t'(1);
            r_ny    <= cnt_t'(1);
            r_state <= ST_COUNT;
          end
        end
        ST_COUNT: begin
          if (abort) begin
            r_state <= ST_IDLE;
          end else if (w_count_done) begin
            r_state <= ST_SCAN;
          end else begin
            if (w_rx_ge) begin
              r_rx <= r_rx - w_s;
              r_nx <= r_nx + cnt_t'(1);
            end
            if (w_ry_ge) begin
              r_ry <= r_ry - w_s;
              r_ny <= r_ny + cnt_t'(1);
            end
          end
        end
        ST_SCAN: begin
          if (abort) begin
            r_out_valid <= 1'b0;
            r_last      <= 1'b0;
            r_state     <= ST_IDLE;
          end else if (w_accept && w_scan_end) begin
            r_out_valid <= 1'b0;
            r_last      <= 1'b0;
            r_done      <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase

      if (w_ld && !abort) begin
        r_xi        <= w_nxt_xi;
        r_yb        <= w_nxt_yb;
        r_out_valid <= 1'b1;
        r_out_x     <= w_nxt_x;
        r_out_y     <= w_nxt_y;
        r_lane_mask <= w_nxt_mask;
        r_x_therm   <= w_x_therm;
        r_y_therm   <= w_y_therm;
        r_last      <= w_nxt_last;
      end
    end
  end

  assign busy      = (r_state != ST_IDLE);
  assign cfg_err   = r_cfg_err;
  assign out_valid = r_out_valid;
  assign out_x     = r_out_x;
  assign out_y     = r_out_y;
  assign lane_mask = r_lane_mask;
  assign x_therm   = r_x_therm;
  assign y_therm   = r_y_therm;
  assign last      = r_last;
  assign done      = r_done;

endmodule
